// File: rtl/branch_predictor_if.sv
// Predictor <-> pipeline bundle: fetch lookup, ID jump resolve, EX branch resolve, miss/redirect, stats.
// Latency: carries no state of its own; every signal is a plain wire between the two sides.
// Backpressure: none on the bundle; EX-side stalls are expressed through freeze_ex.
// Ports (slave = predictor view):
//   in : pc_if, jump_valid_id, pc_id, jump_target_id, pred_taken_id, pred_target_id,
//        branch_valid_ex, freeze_ex, pc_ex, branch_taken_ex, branch_target_ex, pred_taken_ex, pred_target_ex
//   out: next_pc_pred, pred_taken_if, jump_miss, branch_miss, redirect_pc, num_branch, num_miss
interface branch_predictor_if #(
   parameter int WORD_SIZE = 16
);
   // fetch lookup
   logic [WORD_SIZE-1:0] pc_if;
   logic [WORD_SIZE-1:0] next_pc_pred;
   logic                 pred_taken_if;
   // ID jump resolution
   logic                 jump_valid_id;
   logic [WORD_SIZE-1:0] pc_id;
   logic [WORD_SIZE-1:0] jump_target_id;
   logic                 pred_taken_id;
   logic [WORD_SIZE-1:0] pred_target_id;
   // EX branch resolution
   logic                 branch_valid_ex;
   logic                 freeze_ex;
   logic [WORD_SIZE-1:0] pc_ex;
   logic                 branch_taken_ex;
   logic [WORD_SIZE-1:0] branch_target_ex;
   logic                 pred_taken_ex;
   logic [WORD_SIZE-1:0] pred_target_ex;
   // miss reporting and statistics
   logic                 jump_miss;
   logic                 branch_miss;
   logic [WORD_SIZE-1:0] redirect_pc;
   logic [15:0]          num_branch;
   logic [15:0]          num_miss;

   modport master (
      output pc_if, jump_valid_id, pc_id, jump_target_id, pred_taken_id, pred_target_id,
             branch_valid_ex, freeze_ex, pc_ex, branch_taken_ex, branch_target_ex,
             pred_taken_ex, pred_target_ex,
      input  next_pc_pred, pred_taken_if, jump_miss, branch_miss, redirect_pc,
             num_branch, num_miss
   );

   modport slave (
      input  pc_if, jump_valid_id, pc_id, jump_target_id, pred_taken_id, pred_target_id,
             branch_valid_ex, freeze_ex, pc_ex, branch_taken_ex, branch_target_ex,
             pred_taken_ex, pred_target_ex,
      output next_pc_pred, pred_taken_if, jump_miss, branch_miss, redirect_pc,
             num_branch, num_miss
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; predicts next fetch PC, flags ID jump / EX branch misses.
// Latency: lookup, miss and redirect are combinational; table and statistic updates land on the next clk edge.
// Backpressure: freeze_ex blocks EX-side table/stat updates but not branch_miss; ID writes are idempotent.
// Ports: clk, reset (async, active-high), bp (branch_predictor_if.slave) carrying all pipeline signals.
module branch_predictor #(
   parameter int WORD_SIZE = 16,
   parameter int IDX_BITS  = 4,
   parameter bit PREDICT   = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   branch_predictor_if.slave  bp
);
   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int TAG_W   = WORD_SIZE - IDX_BITS;
   localparam logic [WORD_SIZE-1:0] PC_INC = WORD_SIZE'(1);

   logic [ENTRIES-1:0]   valid_q;
   logic [TAG_W-1:0]     tag_q    [ENTRIES];
   logic [WORD_SIZE-1:0] target_q [ENTRIES];
   logic [1:0]           ctr_q    [ENTRIES];
   logic [15:0]          num_branch_q, num_branch_d;
   logic [15:0]          num_miss_q,   num_miss_d;

   // index/tag split for each of the three access ports
   logic [IDX_BITS-1:0] idx_if, idx_id, idx_ex;
   logic [TAG_W-1:0]    tag_if, tag_id, tag_ex;
   assign idx_if = bp.pc_if[IDX_BITS-1:0];
   assign idx_id = bp.pc_id[IDX_BITS-1:0];
   assign idx_ex = bp.pc_ex[IDX_BITS-1:0];
   assign tag_if = bp.pc_if[WORD_SIZE-1:IDX_BITS];
   assign tag_id = bp.pc_id[WORD_SIZE-1:IDX_BITS];
   assign tag_ex = bp.pc_ex[WORD_SIZE-1:IDX_BITS];

   // Fetch lookup reads the registered table, so a same-cycle write is seen one cycle later.
   logic hit_if;
   assign hit_if           = valid_q[idx_if] && (tag_q[idx_if] == tag_if) && ctr_q[idx_if][1];
   assign bp.pred_taken_if = hit_if && PREDICT;
   assign bp.next_pc_pred  = bp.pred_taken_if ? target_q[idx_if] : bp.pc_if + PC_INC;

   // Miss detection: an EX branch miss flushes ID, so it masks any ID jump verdict.
   logic branch_miss, jump_miss;
   assign branch_miss = bp.branch_valid_ex &&
                        ((bp.branch_taken_ex != bp.pred_taken_ex) ||
                         (bp.branch_taken_ex && (bp.pred_target_ex != bp.branch_target_ex)));
   assign jump_miss   = bp.jump_valid_id && !branch_miss &&
                        (!bp.pred_taken_id || (bp.pred_target_id != bp.jump_target_id));

   assign bp.branch_miss = branch_miss;
   assign bp.jump_miss   = jump_miss;
   assign bp.redirect_pc = branch_miss ? (bp.branch_taken_ex ? bp.branch_target_ex : bp.pc_ex + PC_INC)
                                       : bp.jump_target_id;

   // Update qualifiers
   logic ex_upd, ex_hit, id_upd, id_wr;
   assign ex_upd = bp.branch_valid_ex && !bp.freeze_ex;
   assign ex_hit = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
   assign id_upd = bp.jump_valid_id && !branch_miss;
   // EX owns the entry when both ports target the same index in one cycle.
   assign id_wr  = id_upd && !(ex_upd && (idx_id == idx_ex));

   always_comb begin
      num_branch_d = num_branch_q + 16'(ex_upd) + 16'(id_upd);
      num_miss_d   = num_miss_q + 16'(branch_miss && !bp.freeze_ex) + 16'(jump_miss);
   end

   assign bp.num_branch = num_branch_q;
   assign bp.num_miss   = num_miss_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q      <= '0;
         num_branch_q <= '0;
         num_miss_q   <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else begin
         num_branch_q <= num_branch_d;
         num_miss_q   <= num_miss_d;
         if (ex_upd) begin
            if (ex_hit) begin
               if (bp.branch_taken_ex) begin
                  if (ctr_q[idx_ex] != 2'b11) ctr_q[idx_ex] <= ctr_q[idx_ex] + 2'b01;
                  target_q[idx_ex] <= bp.branch_target_ex;
               end else begin
                  if (ctr_q[idx_ex] != 2'b00) ctr_q[idx_ex] <= ctr_q[idx_ex] - 2'b01;
               end
            end else if (bp.branch_taken_ex) begin
               // allocate weakly-taken; not-taken misses leave the table alone
               valid_q[idx_ex]  <= 1'b1;
               tag_q[idx_ex]    <= tag_ex;
               target_q[idx_ex] <= bp.branch_target_ex;
               ctr_q[idx_ex]    <= 2'b10;
            end
         end
         if (id_wr) begin
            valid_q[idx_id]  <= 1'b1;
            tag_q[idx_id]    <= tag_id;
            target_q[idx_id] <= bp.jump_target_id;
            ctr_q[idx_id]    <= 2'b11;
         end
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: one PREDICT=1 instance and one PREDICT=0 instance.
// Inputs change 1ns after a rising edge; outputs are sampled 1ns later, well clear of the next edge.
// Checks are immediate assertions; each failure is counted and reported with observed/expected values.
module tb_branch_predictor;
   logic clk;
   logic reset;
   int   n_assert;
   int   n_fail;

   branch_predictor_if #(.WORD_SIZE(16)) ifa ();
   branch_predictor_if #(.WORD_SIZE(16)) ifb ();

   branch_predictor #(.WORD_SIZE(16), .IDX_BITS(4), .PREDICT(1'b1)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bp    (ifa)
   );

   branch_predictor #(.WORD_SIZE(16), .IDX_BITS(4), .PREDICT(1'b0)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bp    (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_a();
      ifa.jump_valid_id    = 1'b0;
      ifa.pc_id            = '0;
      ifa.jump_target_id   = '0;
      ifa.pred_taken_id    = 1'b0;
      ifa.pred_target_id   = '0;
      ifa.branch_valid_ex  = 1'b0;
      ifa.freeze_ex        = 1'b0;
      ifa.pc_ex            = '0;
      ifa.branch_taken_ex  = 1'b0;
      ifa.branch_target_ex = '0;
      ifa.pred_taken_ex    = 1'b0;
      ifa.pred_target_ex   = '0;
   endtask

   task automatic idle_b();
      ifb.jump_valid_id    = 1'b0;
      ifb.pc_id            = '0;
      ifb.jump_target_id   = '0;
      ifb.pred_taken_id    = 1'b0;
      ifb.pred_target_id   = '0;
      ifb.branch_valid_ex  = 1'b0;
      ifb.freeze_ex        = 1'b0;
      ifb.pc_ex            = '0;
      ifb.branch_taken_ex  = 1'b0;
      ifb.branch_target_ex = '0;
      ifb.pred_taken_ex    = 1'b0;
      ifb.pred_target_ex   = '0;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset    = 1'b1;
      idle_a();
      idle_b();
      ifa.pc_if = 16'h0010;
      ifb.pc_if = 16'h0000;

      // ---- reset state ----
      tick();
      chk("rst_num_branch", ifa.num_branch, 16'd0);
      chk("rst_num_miss", ifa.num_miss, 16'd0);
      chk("rst_branch_miss", ifa.branch_miss, 1'b0);
      chk("rst_jump_miss", ifa.jump_miss, 1'b0);
      reset = 1'b0;
      settle();
      chk("rst_pred_0010", ifa.pred_taken_if, 1'b0);
      chk("rst_next_0010", ifa.next_pc_pred, 16'h0011);
      ifa.pc_if = 16'hFFFF;
      settle();
      chk("rst_next_wrap", ifa.next_pc_pred, 16'h0000);

      // ---- jump in ID, unpredicted ----
      tick();
      ifa.pc_if          = 16'h0020;
      ifa.jump_valid_id  = 1'b1;
      ifa.pc_id          = 16'h0020;
      ifa.jump_target_id = 16'h0040;
      ifa.pred_taken_id  = 1'b0;
      ifa.pred_target_id = 16'h0021;
      settle();
      chk("jmp_miss", ifa.jump_miss, 1'b1);
      chk("jmp_bmiss", ifa.branch_miss, 1'b0);
      chk("jmp_redirect", ifa.redirect_pc, 16'h0040);
      chk("jmp_rdw_pred", ifa.pred_taken_if, 1'b0);
      chk("jmp_rdw_next", ifa.next_pc_pred, 16'h0021);
      tick();
      idle_a();
      settle();
      chk("jmp_pred", ifa.pred_taken_if, 1'b1);
      chk("jmp_next", ifa.next_pc_pred, 16'h0040);
      chk("jmp_nbr", ifa.num_branch, 16'd1);
      chk("jmp_nmiss", ifa.num_miss, 16'd1);
      // same jump, now correctly predicted
      ifa.jump_valid_id  = 1'b1;
      ifa.pc_id          = 16'h0020;
      ifa.jump_target_id = 16'h0040;
      ifa.pred_taken_id  = 1'b1;
      ifa.pred_target_id = 16'h0040;
      settle();
      chk("jmp_hit_nomiss", ifa.jump_miss, 1'b0);
      tick();
      idle_a();
      ifa.pc_if = 16'h0010;   // same index 0, different tag
      settle();
      chk("jmp_hit_nbr", ifa.num_branch, 16'd2);
      chk("jmp_hit_nmiss", ifa.num_miss, 16'd1);
      chk("tag_mismatch_pred", ifa.pred_taken_if, 1'b0);
      chk("tag_mismatch_next", ifa.next_pc_pred, 16'h0011);

      // ---- EX branch allocation and counter training ----
      ifa.branch_valid_ex  = 1'b1;
      ifa.pc_ex            = 16'h0031;
      ifa.branch_taken_ex  = 1'b1;
      ifa.branch_target_ex = 16'h0050;
      ifa.pred_taken_ex    = 1'b0;
      ifa.pred_target_ex   = 16'h0032;
      settle();
      chk("br_alloc_miss", ifa.branch_miss, 1'b1);
      chk("br_alloc_redirect", ifa.redirect_pc, 16'h0050);
      tick();
      idle_a();
      ifa.pc_if = 16'h0031;
      settle();
      chk("br_ctr10_pred", ifa.pred_taken_if, 1'b1);
      chk("br_ctr10_next", ifa.next_pc_pred, 16'h0050);
      chk("br_alloc_nbr", ifa.num_branch, 16'd3);
      chk("br_alloc_nmiss", ifa.num_miss, 16'd2);
      // not taken, predicted taken -> miss, redirect to fall-through
      ifa.branch_valid_ex  = 1'b1;
      ifa.pc_ex            = 16'h0031;
      ifa.branch_taken_ex  = 1'b0;
      ifa.branch_target_ex = 16'h0050;
      ifa.pred_taken_ex    = 1'b1;
      ifa.pred_target_ex   = 16'h0050;
      settle();
      chk("br_nt1_miss", ifa.branch_miss, 1'b1);
      chk("br_nt1_redirect", ifa.redirect_pc, 16'h0032);
      tick();
      ifa.pred_taken_ex  = 1'b0;
      ifa.pred_target_ex = 16'h0032;
      settle();
      chk("br_ctr01_pred", ifa.pred_taken_if, 1'b0);
      chk("br_ctr01_next", ifa.next_pc_pred, 16'h0032);
      chk("br_nt2_nomiss", ifa.branch_miss, 1'b0);
      tick();
      // counter now 00: one taken outcome must only reach 01, still not predicted
      ifa.branch_taken_ex = 1'b1;
      settle();
      chk("br_t_after00_miss", ifa.branch_miss, 1'b1);
      tick();
      idle_a();
      ifa.pc_if = 16'h0031;
      settle();
      chk("br_ctr00_up_pred", ifa.pred_taken_if, 1'b0);
      chk("br_train_nbr", ifa.num_branch, 16'd6);
      chk("br_train_nmiss", ifa.num_miss, 16'd4);

      // ---- freeze_ex holds off EX updates but not branch_miss ----
      ifa.pc_if            = 16'h0035;
      ifa.branch_valid_ex  = 1'b1;
      ifa.freeze_ex        = 1'b1;
      ifa.pc_ex            = 16'h0035;
      ifa.branch_taken_ex  = 1'b1;
      ifa.branch_target_ex = 16'h0060;
      ifa.pred_taken_ex    = 1'b0;
      ifa.pred_target_ex   = 16'h0036;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("frz_bmiss", ifa.branch_miss, 1'b1);
         tick();
      end
      chk("frz_nbr_hold", ifa.num_branch, 16'd6);
      chk("frz_nmiss_hold", ifa.num_miss, 16'd4);
      chk("frz_no_alloc", ifa.pred_taken_if, 1'b0);
      ifa.freeze_ex = 1'b0;
      tick();
      idle_a();
      settle();
      chk("frz_nbr_after", ifa.num_branch, 16'd7);
      chk("frz_nmiss_after", ifa.num_miss, 16'd5);
      chk("frz_alloc_pred", ifa.pred_taken_if, 1'b1);
      chk("frz_alloc_next", ifa.next_pc_pred, 16'h0060);

      // ---- branch miss masks an ID jump to the same index ----
      ifa.branch_valid_ex  = 1'b1;
      ifa.pc_ex            = 16'h0031;
      ifa.branch_taken_ex  = 1'b0;
      ifa.branch_target_ex = 16'h0050;
      ifa.pred_taken_ex    = 1'b1;
      ifa.pred_target_ex   = 16'h0050;
      ifa.jump_valid_id    = 1'b1;
      ifa.pc_id            = 16'h0041;
      ifa.jump_target_id   = 16'h0070;
      ifa.pred_taken_id    = 1'b0;
      ifa.pred_target_id   = 16'h0042;
      settle();
      chk("mask_bmiss", ifa.branch_miss, 1'b1);
      chk("mask_jmiss", ifa.jump_miss, 1'b0);
      chk("mask_redirect", ifa.redirect_pc, 16'h0032);
      tick();
      idle_a();
      ifa.pc_if = 16'h0041;
      settle();
      chk("mask_no_id_write", ifa.pred_taken_if, 1'b0);
      chk("mask_next", ifa.next_pc_pred, 16'h0042);
      chk("mask_nbr", ifa.num_branch, 16'd8);
      chk("mask_nmiss", ifa.num_miss, 16'd6);

      // ---- PREDICT=0: every taken branch / jump misses ----
      for (int i = 0; i < 10; i++) begin
         idle_b();
         if (i % 2 == 0) begin
            ifb.jump_valid_id  = 1'b1;
            ifb.pc_id          = 16'h0020 + 16'(i);
            ifb.jump_target_id = 16'h0100 + 16'(i);
            ifb.pred_target_id = 16'h0021 + 16'(i);
            settle();
            chk("np_jmiss", ifb.jump_miss, 1'b1);
         end else begin
            ifb.branch_valid_ex  = 1'b1;
            ifb.pc_ex            = 16'h0020 + 16'(i);
            ifb.branch_taken_ex  = 1'b1;
            ifb.branch_target_ex = 16'h0200 + 16'(i);
            ifb.pred_target_ex   = 16'h0021 + 16'(i);
            settle();
            chk("np_bmiss", ifb.branch_miss, 1'b1);
         end
         tick();
      end
      idle_b();
      ifb.pc_if = 16'h0020;
      settle();
      chk("np_pred", ifb.pred_taken_if, 1'b0);
      chk("np_next", ifb.next_pc_pred, 16'h0021);
      chk("np_nbr", ifb.num_branch, 16'd10);
      chk("np_nmiss", ifb.num_miss, 16'd10);

      // ---- asynchronous reset mid-operation ----
      ifa.pc_if = 16'h0035;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_nbr", ifa.num_branch, 16'd0);
      chk("arst_nmiss", ifa.num_miss, 16'd0);
      chk("arst_pred", ifa.pred_taken_if, 1'b0);
      chk("arst_next", ifa.next_pc_pred, 16'h0036);
      chk("arst_b_nbr", ifb.num_branch, 16'd0);
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
